// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write arbiter.
// The optional post-reset clear sequence is enabled with REGFILE_CLEAR_EN.
package regfile_ctrl_pkg;

  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_DEPTH  = 32;
  localparam int ZERO_REG       = 0;

  localparam logic [REGFILE_ADDR_W-1:0] LAST_REG =
    REGFILE_ADDR_W'(REGFILE_DEPTH - 1);

  typedef enum logic {
    CLEAR,
    ARB
  } ctrl_state_t;

  // Next requester index in the ring, wrapping past n-1 to 0.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping.
// Produces a one-hot grant and the index of the granted requester.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   cand;

  // First requesting slot at or after ptr wins; later slots are masked.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = (int'(ptr) < NUM_REQ) ? int'(ptr) : 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
      cand = wrap_inc(cand, NUM_REQ);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the regfile write port among NUM_REQ requesters.
// Define REGFILE_CLEAR_EN to zero registers 1..31 after every reset.
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = REGFILE_DATA_W,
  parameter int ADDR_W  = REGFILE_ADDR_W
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        ReqValid,
  output logic [NUM_REQ-1:0]        ReqReady,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteRegister,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      Busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   idx;
  logic               arb_en;
  logic               xfer;
  logic               clr_wr;
  logic [ADDR_W-1:0]  clr_addr;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  data_sel;

`ifdef REGFILE_CLEAR_EN
  ctrl_state_t               state;
  ctrl_state_t               state_nxt;
  logic [REGFILE_ADDR_W-1:0] cnt;
  logic [REGFILE_ADDR_W-1:0] cnt_nxt;

  // State and clear counter; reset restarts the clear at register 1.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= CLEAR;
      cnt   <= REGFILE_ADDR_W'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Issue one clear write per cycle until register 31 has gone out.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_wr    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_wr  = 1'b1;
        cnt_nxt = cnt + REGFILE_ADDR_W'(1);
        if (cnt == LAST_REG) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        state_nxt = ARB;
      end
    endcase
  end

  assign clr_addr = ADDR_W'(cnt);
  assign arb_en   = (state == ARB);
  assign Busy     = (state == CLEAR);
`else
  assign clr_wr   = 1'b0;
  assign clr_addr = '0;
  assign arb_en   = 1'b1;
  assign Busy     = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (ReqValid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx)
  );

  // Handshake is only offered while arbitrating and out of reset.
  assign ReqReady = (Reset_n && arb_en) ? grant : '0;
  assign xfer     = |ReqReady;
  assign addr_sel = ReqAddr[int'(idx)*ADDR_W +: ADDR_W];
  assign data_sel = ReqData[int'(idx)*DATA_W +: DATA_W];

  // Advance the rotation past whoever was just served.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= IDX_W'(wrap_inc(int'(idx), NUM_REQ));
    end
  end

  // Registered regfile port; register 0 writes never raise RegWrite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      unique case (1'b1)
        clr_wr: begin
          RegWrite      <= 1'b1;
          WriteRegister <= clr_addr;
          WriteData     <= '0;
        end
        xfer: begin
          RegWrite      <= (addr_sel != ADDR_W'(ZERO_REG));
          WriteRegister <= addr_sel;
          WriteData     <= data_sel;
        end
        default: begin
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter with a small regfile model.
// Clear-sequence scenarios follow REGFILE_CLEAR_EN when it is defined.
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [N-1:0]  ReqValid = '0;
  logic [N-1:0]  ReqReady;
  logic [N*AW-1:0] ReqAddr = '0;
  logic [N*DW-1:0] ReqData = '0;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          Busy;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  logic [31:0] rf [32];

  regfile_write_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .ADDR_W  (AW)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  // Regfile model: register 0 is hardwired, others store on RegWrite.
  always @(posedge Clk) begin
    if (RegWrite) begin
      wr_count <= wr_count + 1;
      if (WriteRegister != 0) rf[WriteRegister] <= WriteData;
    end
  end

  task automatic set_req(input int i, input logic [4:0] a,
                         input logic [31:0] d);
    ReqAddr[i*AW +: AW] = a;
    ReqData[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    int k;
    @(negedge Clk);
    Reset_n  = 1'b0;
    ReqValid = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    k = 0;
    while (Busy !== 1'b0 && k < 64) begin
      @(negedge Clk);
      k++;
    end
    n_tests++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_timeout: Busy=%b after %0d cycles, need 0",
               Busy, k);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
    ReqValid = 4'b1111;
    Reset_n  = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    n_tests++;
    if (RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL rst_regwrite: got %b need 0", RegWrite);
    end
    n_tests++;
    if (WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_addr_data: got %0d/%h need 0/0",
               WriteRegister, WriteData);
    end
    n_tests++;
    if (ReqReady !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ready: got %b need 0000", ReqReady);
    end
    n_tests++;
`ifdef REGFILE_CLEAR_EN
    if (Busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy: got %b need 1", Busy);
    end
`else
    if (Busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b need 0", Busy);
    end
`endif
  endtask

  task automatic test_clear_sequence();
    @(negedge Clk);
    Reset_n = 1'b1;
`ifdef REGFILE_CLEAR_EN
    for (int k = 1; k <= 31; k++) begin
      #1;
      n_tests++;
      if (ReqReady !== 4'b0000 || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_ready_busy[%0d]: got %b/%b need 0000/1",
                 k, ReqReady, Busy);
      end
      @(posedge Clk); #1;
      n_tests++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'(k) ||
          WriteData !== 32'd0) begin
        n_fail++;
        $display("FAIL clr_write[%0d]: got %b/%0d/%h need 1/%0d/0",
                 k, RegWrite, WriteRegister, WriteData, k);
      end
      @(negedge Clk);
    end
`endif
    #1;
    n_tests++;
    if (Busy !== 1'b0 || ReqReady !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant: got busy %b ready %b need 0/0001",
               Busy, ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd1 ||
        WriteData !== 32'hA000_0000) begin
      n_fail++;
      $display("FAIL first_write: got %b/%0d/%h need 1/1/a0000000",
               RegWrite, WriteRegister, WriteData);
    end
`ifdef REGFILE_CLEAR_EN
    n_tests++;
    if (rf[31] !== 32'd0 || rf[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_rf: got r1=%h r31=%h need 0/0", rf[1], rf[31]);
    end
`endif
    @(negedge Clk);
    ReqValid = '0;
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
    ReqValid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      #1;
      n_tests++;
      if (ReqReady !== 4'(1 << g)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b need %b",
                 k, ReqReady, 4'(1 << g));
      end
      @(posedge Clk); #1;
      n_tests++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'(g + 1) ||
          WriteData !== 32'hA000_0000 + g) begin
        n_fail++;
        $display("FAIL rr_write[%0d]: got %b/%0d/%h need 1/%0d/%h",
                 k, RegWrite, WriteRegister, WriteData, g + 1,
                 32'hA000_0000 + g);
      end
      @(negedge Clk);
    end
    ReqValid = '0;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0000) begin
      n_fail++; $display("FAIL rr_idle_ready: got %b need 0000", ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd4 ||
        WriteData !== 32'hA000_0003) begin
      n_fail++;
      $display("FAIL rr_idle_hold: got %b/%0d/%h need 0/4/a0000003",
               RegWrite, WriteRegister, WriteData);
    end
    @(negedge Clk);
  endtask

  task automatic test_reg0_discard();
    int c0;
    do_reset();
    set_req(2, 5'd0, 32'hDEAD_BEEF);
    ReqValid = 4'b0100;
    c0 = wr_count;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0100) begin
      n_fail++; $display("FAIL r0_ready: got %b need 0100", ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 ||
        WriteData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL r0_port: got %b/%0d/%h need 0/0/deadbeef",
               RegWrite, WriteRegister, WriteData);
    end
    @(negedge Clk);
    ReqValid = '0;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0000) begin
      n_fail++; $display("FAIL r0_pulse: got %b need 0000", ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b0 || wr_count !== c0) begin
      n_fail++;
      $display("FAIL r0_nowrite: got we %b writes %0d need 0/%0d",
               RegWrite, wr_count - c0, 0);
    end
    @(negedge Clk);
  endtask

  task automatic test_pointer_skip();
    int g;
    do_reset();
    set_req(0, 5'd10, 32'hB000_0000);
    set_req(3, 5'd13, 32'hB000_0003);
    ReqValid = 4'b0001;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0001) begin
      n_fail++; $display("FAIL skip_pre: got %b need 0001", ReqReady);
    end
    @(negedge Clk);
    ReqValid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 3 : 0;
      #1;
      n_tests++;
      if (ReqReady !== 4'(1 << g)) begin
        n_fail++;
        $display("FAIL skip_grant[%0d]: got %b need %b",
                 k, ReqReady, 4'(1 << g));
      end
      @(posedge Clk); #1;
      n_tests++;
      if (WriteRegister !== 5'(10 + g) || RegWrite !== 1'b1) begin
        n_fail++;
        $display("FAIL skip_write[%0d]: got %b/%0d need 1/%0d",
                 k, RegWrite, WriteRegister, 10 + g);
      end
      @(negedge Clk);
    end
    ReqValid = '0;
  endtask

  task automatic test_stall_hold();
    int c0;
    do_reset();
    set_req(1, 5'd5, 32'h0000_1234);
    ReqValid = 4'b0010;
    c0 = wr_count;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0010) begin
      n_fail++; $display("FAIL hold_ready: got %b need 0010", ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 ||
        WriteData !== 32'h1234) begin
      n_fail++;
      $display("FAIL hold_write: got %b/%0d/%h need 1/5/1234",
               RegWrite, WriteRegister, WriteData);
    end
    @(negedge Clk);
    ReqValid = '0;
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b0 || wr_count !== c0 + 1) begin
      n_fail++;
      $display("FAIL hold_once: got we %b writes %0d need 0/1",
               RegWrite, wr_count - c0);
    end
    n_tests++;
    if (rf[5] !== 32'h1234) begin
      n_fail++; $display("FAIL hold_rf5: got %h need 1234", rf[5]);
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    set_req(1, 5'd6, 32'h1111);
    ReqValid = 4'b0010;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_g0: got %b need 0010", ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd6 ||
        WriteData !== 32'h1111) begin
      n_fail++;
      $display("FAIL b2b_w0: got %b/%0d/%h need 1/6/1111",
               RegWrite, WriteRegister, WriteData);
    end
    @(negedge Clk);
    set_req(1, 5'd7, 32'h2222);
    #1;
    n_tests++;
    if (ReqReady !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_g1: got %b need 0010", ReqReady);
    end
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 ||
        WriteData !== 32'h2222) begin
      n_fail++;
      $display("FAIL b2b_w1: got %b/%0d/%h need 1/7/2222",
               RegWrite, WriteRegister, WriteData);
    end
    @(negedge Clk);
    ReqValid = '0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);
`ifdef REGFILE_CLEAR_EN
    @(negedge Clk);
    Reset_n  = 1'b0;
    ReqValid = '0;
    @(negedge Clk);
    Reset_n  = 1'b1;
    ReqValid = 4'b1111;
    repeat (10) @(posedge Clk);
    #1;
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd10) begin
      n_fail++;
      $display("FAIL mid_pre: got %b/%0d need 1/10",
               RegWrite, WriteRegister);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 ||
        Busy !== 1'b1 || ReqReady !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_async: got %b/%0d/%b/%b need 0/0/1/0000",
               RegWrite, WriteRegister, Busy, ReqReady);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      #1;
      n_tests++;
      if (ReqReady !== 4'b0000) begin
        n_fail++;
        $display("FAIL mid_stall[%0d]: got %b need 0000", k, ReqReady);
      end
      @(posedge Clk); #1;
      n_tests++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'(k)) begin
        n_fail++;
        $display("FAIL mid_clr[%0d]: got %b/%0d need 1/%0d",
                 k, RegWrite, WriteRegister, k);
      end
      @(negedge Clk);
    end
    #1;
    n_tests++;
    if (ReqReady !== 4'b0001) begin
      n_fail++; $display("FAIL mid_resume: got %b need 0001", ReqReady);
    end
`else
    do_reset();
    ReqValid = 4'b0001;
    @(posedge Clk); #1;
    n_tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd1) begin
      n_fail++;
      $display("FAIL mid_pre: got %b/%0d need 1/1",
               RegWrite, WriteRegister);
    end
    ReqValid = 4'b1111;
    #2 Reset_n = 1'b0;
    #1;
    n_tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 ||
        ReqReady !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_async: got %b/%0d/%b need 0/0/0000",
               RegWrite, WriteRegister, ReqReady);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    n_tests++;
    if (ReqReady !== 4'b0001) begin
      n_fail++; $display("FAIL mid_resume: got %b need 0001", ReqReady);
    end
`endif
    @(negedge Clk);
    ReqValid = '0;
  endtask

  initial begin
    test_reset();
    test_clear_sequence();
    test_round_robin();
    test_reg0_discard();
    test_pointer_skip();
    test_stall_hold();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, need finish", $time);
    $fatal(1);
  end

endmodule
